// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants plus the immediate-format enum and decoded-entry struct.
// The struct is sized for the widest legal XLEN; narrower stages use only its low bits.
package riscv_pkg;

    localparam int unsigned MAX_XLEN = 64;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FmtNone,
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtZ,
        FmtSh
    } imm_fmt_e;

    typedef struct packed {
        logic [MAX_XLEN-1:0] imm;
        logic [MAX_XLEN-1:0] target;
        imm_fmt_e            fmt;
        logic                illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the immediate decode stage.
// The slave modport is the stage's view; the master modport is the surrounding pipeline.
interface imm_decode_stage_if import riscv_pkg::*; #(
    parameter int unsigned XLEN = 32
);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    imm_fmt_e        out_fmt;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );

endinterface

// File: rtl/imm_decode_comb.sv
// Purely combinational immediate decode: (instr, pc) -> immediate, PC-relative target,
// format and illegal flag. Results are zero-padded to MAX_XLEN in the entry struct.
module imm_decode_comb import riscv_pkg::*; #(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output imm_entry_t      entry_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    imm_fmt_e        fmt;
    logic            illegal;
    logic            pc_rel;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    always_comb begin
        imm     = '0;
        fmt     = FmtNone;
        illegal = 1'b0;
        pc_rel  = 1'b0;
        unique case (opcode)
            OPCODE_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt = FmtSh;
                    imm = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
                end else begin
                    fmt = FmtI;
                    imm = XLEN'($signed(instr_i[31:20]));
                end
            end
            OPCODE_LOAD, OPCODE_JALR: begin
                // JALR target needs rs1, so it stays zero and execute computes it.
                fmt = FmtI;
                imm = XLEN'($signed(instr_i[31:20]));
            end
            OPCODE_STORE: begin
                fmt = FmtS;
                imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            end
            OPCODE_BRANCH: begin
                fmt    = FmtB;
                pc_rel = 1'b1;
                imm    = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                        instr_i[11:8], 1'b0}));
            end
            OPCODE_LUI: begin
                fmt = FmtU;
                imm = XLEN'($signed({instr_i[31:12], 12'b0}));
            end
            OPCODE_AUIPC: begin
                fmt    = FmtU;
                pc_rel = 1'b1;
                imm    = XLEN'($signed({instr_i[31:12], 12'b0}));
            end
            OPCODE_JAL: begin
                fmt    = FmtJ;
                pc_rel = 1'b1;
                imm    = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                        instr_i[30:21], 1'b0}));
            end
            OPCODE_SYSTEM: begin
                if (funct3[2]) begin
                    fmt = FmtZ;
                    imm = XLEN'(instr_i[19:15]);
                end
            end
            OPCODE_FENCE, OPCODE_OP: begin
                fmt = FmtNone;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Target wraps modulo 2^XLEN before it is widened.
    assign target = pc_rel ? (pc_i + imm) : '0;

    assign entry_o.imm     = MAX_XLEN'(imm);
    assign entry_o.target  = MAX_XLEN'(target);
    assign entry_o.fmt     = fmt;
    assign entry_o.illegal = illegal;

endmodule

// File: rtl/imm_decode_stage.sv
// Pipelined immediate decode stage: one-cycle latency, main output register plus a skid
// entry so in_ready can be a registered signal while sustaining full throughput.
module imm_decode_stage import riscv_pkg::*; #(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    imm_decode_stage_if.slave  bus
);

    if (!(XLEN == 32 || XLEN == 64)) begin : gen_xlen_check
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        imm_fmt_e        fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    localparam entry_t ResetEntry = '{imm: '0, target: '0, fmt: FmtNone, illegal: 1'b0};

    imm_entry_t dec_full;
    entry_t     dec;
    state_e     state_q, state_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       accept;
    logic       drain;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i (bus.in_instr),
        .pc_i    (bus.in_pc),
        .entry_o (dec_full)
    );

    assign dec.imm     = dec_full.imm[XLEN-1:0];
    assign dec.target  = dec_full.target[XLEN-1:0];
    assign dec.fmt     = dec_full.fmt;
    assign dec.illegal = dec_full.illegal;

    if (XLEN < MAX_XLEN) begin : gen_unused_hi
        logic unused_hi;
        assign unused_hi = ^{dec_full.imm[MAX_XLEN-1:XLEN], dec_full.target[MAX_XLEN-1:XLEN]};
    end

    assign bus.in_ready  = (state_q != StTwo);
    assign bus.out_valid = (state_q != StEmpty);
    assign accept        = bus.in_valid && bus.in_ready;
    assign drain         = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        main_d = dec;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = StTwo;
                    end
                end
                StTwo: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= ResetEntry;
            skid_q  <= ResetEntry;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.out_imm     = main_q.imm;
    assign bus.out_target  = main_q.target;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Drives an XLEN=32 and an XLEN=64 stage in lockstep and checks both against a FIFO
// reference model that decodes immediates arithmetically from the instruction fields.
module tb_imm_decode_stage;

    localparam int unsigned FNone = 0, FI = 1, FS = 2, FB = 3, FU = 4, FJ = 5, FZ = 6, FSh = 7;

    typedef struct {
        longint unsigned imm;
        longint unsigned target;
        int unsigned     fmt;
        bit              illegal;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t q32[$];
    exp_t q64[$];

    imm_decode_stage_if #(.XLEN(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64)) b64 ();

    imm_decode_stage #(.XLEN(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b32)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint unsigned v, input int bits);
        longint r;
        r = longint'(v);
        if (((v >> (bits - 1)) & 1) != 0) r = r - (longint'(1) << bits);
        return r;
    endfunction

    function automatic exp_t ref_decode(input bit [31:0] instr, input longint unsigned pc,
                                        input int xlen);
        exp_t            e;
        longint unsigned w, mask, f3;
        longint          s;
        bit              rel;
        w    = instr;
        f3   = (w >> 12) & 7;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        s    = 0;
        rel  = 0;
        e    = '{imm: 0, target: 0, fmt: FNone, illegal: 0};
        case (w & 127)
            'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    e.fmt = FSh;
                    s = longint'((w >> 20) & ((xlen == 64) ? 63 : 31));
                end else begin
                    e.fmt = FI;
                    s = sx(w >> 20, 12);
                end
            end
            'h03, 'h67: begin e.fmt = FI; s = sx(w >> 20, 12); end
            'h23: begin e.fmt = FS; s = sx(((w >> 25) * 32) + ((w >> 7) & 31), 12); end
            'h63: begin
                e.fmt = FB; rel = 1;
                s = sx(((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048
                       + ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2, 13);
            end
            'h37: begin e.fmt = FU; s = sx(w & 'hFFFF_F000, 32); end
            'h17: begin e.fmt = FU; rel = 1; s = sx(w & 'hFFFF_F000, 32); end
            'h6F: begin
                e.fmt = FJ; rel = 1;
                s = sx(((w >> 31) & 1) * (1 << 20) + ((w >> 12) & 255) * (1 << 12)
                       + ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2, 21);
            end
            'h73: begin
                if (f3 >= 4) begin e.fmt = FZ; s = longint'((w >> 15) & 31); end
            end
            'h0F, 'h33: e.fmt = FNone;
            default: e.illegal = 1;
        endcase
        e.imm    = longint'(s) & mask;
        e.target = rel ? ((pc + e.imm) & mask) : 0;
        return e;
    endfunction

    task automatic check_side(input string tag, input int unsigned n, input exp_t f,
                              input logic irdy, input logic ovld, input logic [63:0] imm,
                              input logic [63:0] tgt, input logic [2:0] fmt, input logic ill);
        check({tag, "_in_ready"}, 64'(irdy), 64'(n < 2));
        check({tag, "_out_valid"}, 64'(ovld), 64'(n > 0));
        if (n > 0) begin
            check({tag, "_imm"}, imm, f.imm);
            check({tag, "_target"}, tgt, f.target);
            check({tag, "_fmt"}, 64'(fmt), 64'(f.fmt));
            check({tag, "_illegal"}, 64'(ill), 64'(f.illegal));
        end
    endtask

    task automatic compare_all();
        exp_t f32, f64;
        f32 = (q32.size() > 0) ? q32[0] : '{imm: 0, target: 0, fmt: 0, illegal: 0};
        f64 = (q64.size() > 0) ? q64[0] : '{imm: 0, target: 0, fmt: 0, illegal: 0};
        check_side("x32", q32.size(), f32, b32.in_ready, b32.out_valid, 64'(b32.out_imm),
                   64'(b32.out_target), b32.out_fmt, b32.out_illegal);
        check_side("x64", q64.size(), f64, b64.in_ready, b64.out_valid, b64.out_imm,
                   b64.out_target, b64.out_fmt, b64.out_illegal);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit v, input bit [31:0] instr, input bit [63:0] pc,
                        input bit rdy, input bit fl);
        exp_t e32, e64;
        bit   acc, drn;
        compare_all();
        b32.in_valid  = v;    b64.in_valid  = v;
        b32.in_instr  = instr; b64.in_instr = instr;
        b32.in_pc     = pc[31:0];
        b64.in_pc     = pc;
        b32.out_ready = rdy;  b64.out_ready = rdy;
        flush         = fl;
        acc = v && (q32.size() < 2);
        drn = (q32.size() > 0) && rdy;
        e32 = ref_decode(instr, longint'(pc[31:0]), 32);
        e64 = ref_decode(instr, pc, 64);
        @(posedge clk);
        if (fl) begin
            q32.delete();
            q64.delete();
        end else begin
            if (drn) begin void'(q32.pop_front()); void'(q64.pop_front()); end
            if (acc) begin q32.push_back(e32); q64.push_back(e64); end
        end
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input bit is64, input logic [63:0] imm,
                              input logic [2:0] fmt, input logic [63:0] tgt);
        if (is64) begin
            check({tag, "_valid"}, 64'(b64.out_valid), 64'd1);
            check({tag, "_imm"}, b64.out_imm, imm);
            check({tag, "_fmt"}, 64'(b64.out_fmt), 64'(fmt));
            check({tag, "_target"}, b64.out_target, tgt);
        end else begin
            check({tag, "_valid"}, 64'(b32.out_valid), 64'd1);
            check({tag, "_imm"}, 64'(b32.out_imm), imm);
            check({tag, "_fmt"}, 64'(b32.out_fmt), 64'(fmt));
            check({tag, "_target"}, 64'(b32.out_target), tgt);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid32"}, 64'(b32.out_valid), 64'd0);
        check({tag, "_ready32"}, 64'(b32.in_ready), 64'd1);
        check({tag, "_imm32"}, 64'(b32.out_imm), 64'd0);
        check({tag, "_tgt32"}, 64'(b32.out_target), 64'd0);
        check({tag, "_fmt32"}, 64'(b32.out_fmt), 64'(FNone));
        check({tag, "_ill32"}, 64'(b32.out_illegal), 64'd0);
        check({tag, "_valid64"}, 64'(b64.out_valid), 64'd0);
        check({tag, "_imm64"}, b64.out_imm, 64'd0);
    endtask

    initial begin
        bit [6:0]  ops [11];
        bit [31:0] instr;
        bit [63:0] pc;
        ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

        rst_n = 1'b0;
        flush = 1'b0;
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, full throughput: each step shows the entry sent by that step.
        step(1, 32'hFFF0_0093, 64'h0, 1, 0);
        expect_out("addi", 0, 64'hFFFF_FFFF, FI, 64'h0);
        step(1, 32'hFE00_0EE3, 64'h100, 1, 0);
        expect_out("beq", 0, 64'hFFFF_FFFC, FB, 64'hFC);
        step(1, 32'hFE00_0EE3, 64'h0, 1, 0);
        expect_out("beq_wrap", 0, 64'hFFFF_FFFC, FB, 64'hFFFF_FFFC);
        step(1, 32'h1234_5097, 64'h1000, 1, 0);
        expect_out("auipc", 0, 64'h1234_5000, FU, 64'h1234_6000);
        step(1, 32'h4030_D093, 64'h0, 1, 0);
        expect_out("srai", 0, 64'h3, FSh, 64'h0);
        step(1, 32'h300F_D073, 64'h0, 1, 0);
        expect_out("csrrwi", 0, 64'h1F, FZ, 64'h0);
        step(1, 32'h8000_0037, 64'h0, 1, 0);
        expect_out("lui64", 1, 64'hFFFF_FFFF_8000_0000, FU, 64'h0);
        step(1, 32'h03F0_D093, 64'h0, 1, 0);
        expect_out("srli64", 1, 64'd63, FSh, 64'h0);
        step(1, 32'h0000_0010, 64'h0, 1, 0);
        check("illegal64", 64'(b64.out_illegal), 64'd1);
        check("illegal32", 64'(b32.out_illegal), 64'd1);
        step(0, 32'h0, 64'h0, 1, 0);

        // Stall with A,B,C: A and B land, C waits upstream, then drains in order.
        step(1, 32'h0010_0093, 64'h10, 0, 0);
        step(1, 32'h0020_0093, 64'h14, 0, 0);
        check("stall_in_ready", 64'(b32.in_ready), 64'd0);
        step(1, 32'h0030_0093, 64'h18, 0, 0);
        step(1, 32'h0030_0093, 64'h18, 1, 0);
        step(1, 32'h0030_0093, 64'h18, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);

        // Flush while two entries are held and a new input is offered.
        step(1, 32'h0040_0093, 64'h20, 0, 0);
        step(1, 32'h0050_0093, 64'h24, 0, 0);
        step(1, 32'h0060_0093, 64'h28, 0, 1);
        check("flush_out_valid", 64'(b32.out_valid), 64'd0);
        check("flush_in_ready", 64'(b32.in_ready), 64'd1);
        step(1, 32'h0070_0093, 64'h2C, 0, 1);
        step(0, 32'h0, 64'h0, 1, 0);

        // Asynchronous reset mid-stream.
        step(1, 32'hFE00_0EE3, 64'h300, 0, 0);
        step(1, 32'h1234_5097, 64'h400, 0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q32.delete();
        q64.delete();
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 600; i++) begin
            int unsigned sel;
            instr = $urandom;
            sel   = $urandom_range(0, 11);
            if (sel < 11) instr[6:0] = ops[sel];
            pc = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) pc[63:32] = 32'hFFFF_FFFF;
            step(($urandom_range(0, 3) != 0), instr, pc, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0));
        end
        compare_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
